// File: rtl/button_pkg.sv
// Shared constants for the button event decoder: default hold/repeat
// periods and the FSM state encoding.
package button_pkg;

    localparam int LONG_CYCLES_DEF   = 100000000;
    localparam int REPEAT_CYCLES_DEF = 20000000;

    localparam logic [1:0] ST_WAIT_REL = 2'd0;
    localparam logic [1:0] ST_IDLE     = 2'd1;
    localparam logic [1:0] ST_PRESSED  = 2'd2;
    localparam logic [1:0] ST_HELD     = 2'd3;

endpackage

// File: rtl/event_timer.sv
// Hold timer: counts enabled cycles, flags when the count equals the
// terminal value; synchronous clear wins over enable.
module event_timer #(
    parameter int W = 27
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] term_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == term_i);

endmodule

// File: rtl/button_event.sv
// Turns a debounced button level into press/release/short/long/repeat
// strobes plus a held level and a wrapping press counter.
module button_event
    import button_pkg::*;
#(
    parameter int LONG_CYCLES   = LONG_CYCLES_DEF,
    parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF,
    parameter int CNT_W         = 27
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_db,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       short_pulse,
    output logic       long_pulse,
    output logic       repeat_pulse,
    output logic       held,
    output logic [7:0] press_count
);

    localparam logic [CNT_W-1:0] LONG_TERM = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_TERM  = CNT_W'(REPEAT_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic             press_q, press_d;
    logic             rel_q, rel_d;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             rep_q, rep_d;
    logic             held_q, held_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             tmr_clr, tmr_en, tmr_tc;
    logic [CNT_W-1:0] tmr_term;

    event_timer #(
        .W (CNT_W)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (tmr_clr),
        .en_i   (tmr_en),
        .term_i (tmr_term),
        .tc_o   (tmr_tc)
    );

    always_comb begin
        state_d  = state_q;
        press_d  = 1'b0;
        rel_d    = 1'b0;
        short_d  = 1'b0;
        long_d   = 1'b0;
        rep_d    = 1'b0;
        cnt_d    = cnt_q;
        tmr_clr  = 1'b0;
        tmr_en   = 1'b0;
        tmr_term = LONG_TERM;
        case (state_q)
            ST_WAIT_REL: begin
                tmr_clr = 1'b1;
                if (!btn_db) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                tmr_clr = 1'b1;
                if (btn_db) begin
                    state_d = ST_PRESSED;
                    press_d = 1'b1;
                    cnt_d   = cnt_q + 8'd1;
                end
            end
            // Release is tested first so it beats a coincident threshold.
            ST_PRESSED: begin
                if (!btn_db) begin
                    state_d = ST_IDLE;
                    rel_d   = 1'b1;
                    short_d = 1'b1;
                    tmr_clr = 1'b1;
                end else if (tmr_tc) begin
                    state_d = ST_HELD;
                    long_d  = 1'b1;
                    tmr_clr = 1'b1;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_HELD: begin
                tmr_term = REP_TERM;
                if (!btn_db) begin
                    state_d = ST_IDLE;
                    rel_d   = 1'b1;
                    tmr_clr = 1'b1;
                end else if (tmr_tc) begin
                    rep_d   = 1'b1;
                    tmr_clr = 1'b1;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            default: begin
                state_d = ST_WAIT_REL;
                tmr_clr = 1'b1;
            end
        endcase
        held_d = (state_d == ST_PRESSED) || (state_d == ST_HELD);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_WAIT_REL;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            short_q <= 1'b0;
            long_q  <= 1'b0;
            rep_q   <= 1'b0;
            held_q  <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            short_q <= short_d;
            long_q  <= long_d;
            rep_q   <= rep_d;
            held_q  <= held_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press_pulse   = press_q;
    assign release_pulse = rel_q;
    assign short_pulse   = short_q;
    assign long_pulse    = long_q;
    assign repeat_pulse  = rep_q;
    assign held          = held_q;
    assign press_count   = cnt_q;

endmodule

// File: tb/tb_button_event.sv
// Scoreboard bench for button_event with LONG_CYCLES=8, REPEAT_CYCLES=4:
// stimulus queues expected pulse events, a monitor pops them as pulses appear.
module tb_button_event;

    localparam logic [4:0] P_PRESS = 5'b10000;
    localparam logic [4:0] P_REL   = 5'b01000;
    localparam logic [4:0] P_SHORT = 5'b00100;
    localparam logic [4:0] P_LONG  = 5'b00010;
    localparam logic [4:0] P_REP   = 5'b00001;

    typedef struct {
        int         e;
        logic [4:0] p;
        logic [7:0] c;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_db = 1'b0;
    logic       press_pulse, release_pulse, short_pulse;
    logic       long_pulse, repeat_pulse, held;
    logic [7:0] press_count;

    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    logic [7:0] exp_cnt = 8'd0;
    exp_t       q[$];

    button_event #(
        .LONG_CYCLES   (8),
        .REPEAT_CYCLES (4),
        .CNT_W         (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_db        (btn_db),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .short_pulse   (short_pulse),
        .long_pulse    (long_pulse),
        .repeat_pulse  (repeat_pulse),
        .held          (held),
        .press_count   (press_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)",
                     name, act, expv, cyc);
        end
    endtask

    function automatic logic [4:0] pulses();
        return {press_pulse, release_pulse, short_pulse,
                long_pulse, repeat_pulse};
    endfunction

    task automatic push(input int e, input logic [4:0] p, input logic [7:0] c);
        exp_t x;
        x.e = e;
        x.p = p;
        x.c = c;
        q.push_back(x);
    endtask

    // Monitor: every pulse must match the head of the queue.
    always @(posedge clk) begin
        exp_t x;
        #1;
        if (pulses() != 5'd0) begin
            if (q.size() == 0) begin
                chk("unexpected_pulse", {27'd0, pulses()}, 32'd0);
            end else begin
                x = q.pop_front();
                chk("pulse_edge", cyc, x.e);
                chk("pulse_vec", {27'd0, pulses()}, {27'd0, x.p});
                chk("pulse_count", {24'd0, press_count}, {24'd0, x.c});
            end
        end
    end

    task automatic start_press(output int e0);
        @(negedge clk);
        e0 = cyc + 1;
        btn_db = 1'b1;
        exp_cnt = exp_cnt + 8'd1;
    endtask

    task automatic release_after(input int n);
        repeat (n) @(negedge clk);
        btn_db = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset(input logic b);
        @(negedge clk);
        rst_n = 1'b0;
        btn_db = b;
        exp_cnt = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_pulses", {27'd0, pulses()}, 32'd0);
        chk("rst_held", {31'd0, held}, 32'd0);
        chk("rst_count", {24'd0, press_count}, 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        int e0;
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;

        // Short press of 3 cycles.
        do_reset(1'b0);
        @(negedge clk);
        start_press(e0);
        push(e0, P_PRESS, exp_cnt);
        push(e0 + 3, P_REL | P_SHORT, exp_cnt);
        @(negedge clk);
        chk("held_pressed", {31'd0, held}, 32'd1);
        release_after(2);
        chk("count_after_short", {24'd0, press_count}, 32'd1);
        chk("held_idle", {31'd0, held}, 32'd0);

        // Held 20 cycles: long, two repeats, release beats third repeat.
        start_press(e0);
        push(e0, P_PRESS, exp_cnt);
        push(e0 + 8, P_LONG, exp_cnt);
        push(e0 + 12, P_REP, exp_cnt);
        push(e0 + 16, P_REP, exp_cnt);
        push(e0 + 20, P_REL, exp_cnt);
        repeat (10) @(negedge clk);
        chk("held_in_held", {31'd0, held}, 32'd1);
        release_after(10);
        chk("held_after_long", {31'd0, held}, 32'd0);

        // Release exactly on the long threshold edge.
        start_press(e0);
        push(e0, P_PRESS, exp_cnt);
        push(e0 + 8, P_REL | P_SHORT, exp_cnt);
        release_after(8);

        // One cycle past threshold gives long, then plain release.
        start_press(e0);
        push(e0, P_PRESS, exp_cnt);
        push(e0 + 8, P_LONG, exp_cnt);
        push(e0 + 9, P_REL, exp_cnt);
        release_after(9);

        // Release on the first repeat edge: no repeat.
        start_press(e0);
        push(e0, P_PRESS, exp_cnt);
        push(e0 + 8, P_LONG, exp_cnt);
        push(e0 + 12, P_REL, exp_cnt);
        release_after(12);

        // Button held through reset: nothing until released.
        do_reset(1'b1);
        repeat (10) @(negedge clk);
        chk("wait_rel_held", {31'd0, held}, 32'd0);
        chk("wait_rel_count", {24'd0, press_count}, 32'd0);
        btn_db = 1'b0;
        start_press(e0);
        push(e0, P_PRESS, exp_cnt);
        push(e0 + 2, P_REL | P_SHORT, exp_cnt);
        release_after(2);
        chk("count_after_wait", {24'd0, press_count}, 32'd1);

        // 256 short presses wrap the counter back to zero.
        do_reset(1'b0);
        @(negedge clk);
        for (int k = 0; k < 256; k++) begin
            start_press(e0);
            push(e0, P_PRESS, exp_cnt);
            push(e0 + 1, P_REL | P_SHORT, exp_cnt);
            release_after(1);
        end
        chk("count_wrap", {24'd0, press_count}, 32'd0);

        // Reset while in HELD with the button still down.
        start_press(e0);
        push(e0, P_PRESS, exp_cnt);
        push(e0 + 8, P_LONG, exp_cnt);
        repeat (10) @(negedge clk);
        chk("held_before_rst", {31'd0, held}, 32'd1);
        rst_n = 1'b0;
        exp_cnt = 8'd0;
        @(negedge clk);
        chk("midheld_pulses", {27'd0, pulses()}, 32'd0);
        chk("midheld_held", {31'd0, held}, 32'd0);
        chk("midheld_count", {24'd0, press_count}, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_held", {31'd0, held}, 32'd0);
        chk("post_rst_count", {24'd0, press_count}, 32'd0);
        btn_db = 1'b0;
        start_press(e0);
        push(e0, P_PRESS, exp_cnt);
        push(e0 + 3, P_REL | P_SHORT, exp_cnt);
        release_after(3);

        repeat (3) @(negedge clk);
        chk("queue_empty", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
